// File: rtl/arb_mux.sv
// arb_mux: N-way, WIDTH-bit selector with a one-entry registered output and
// valid/ready handshakes on every input and on the output. Selection comes
// either from `control` (mode=0) or from a round-robin arbiter (mode=1).
// Optional feature macro: ARB_MUX_STATS_EN adds a 16-bit wrapping
// transfer-in counter on output xfer_count.
module arb_mux #(
   parameter int WIDTH = 32,
   parameter int N     = 16,
   parameter int SEL_W = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic                 mode,
   input  logic [SEL_W-1:0]     control,
   output logic [WIDTH-1:0]     out_data,
   output logic [SEL_W-1:0]     out_src,
   output logic                 out_valid,
   input  logic                 out_ready
`ifdef ARB_MUX_STATS_EN
   ,
   output logic [15:0]          xfer_count
`endif
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t               state_q;
   state_t               state_d;
   logic [WIDTH-1:0]     data_p0;
   logic [SEL_W-1:0]     src_p0;
   logic [SEL_W-1:0]     ptr_p0;
   logic [SEL_W-1:0]     cand;
   logic [SEL_W-1:0]     gsel;
   logic                 grant;
   logic                 load;
   logic                 xfer_in;

   assign load    = (state_q == EMPTY) | out_ready;
   assign xfer_in = rst_n & load & grant;

   // Grant selection: direct index in fixed mode, first valid after ptr in rotate mode
   always_comb begin
      grant = 1'b0;
      gsel  = '0;
      cand  = '0;
      if (mode) begin
         for (int k = 1; k <= N; k++) begin
            cand = SEL_W'((int'(ptr_p0) + k) % N);
            if (!grant && in_valid[cand]) begin
               grant = 1'b1;
               gsel  = cand;
            end
         end
      end else begin
         if (int'(control) < N) begin
            if (in_valid[control]) begin
               grant = 1'b1;
               gsel  = control;
            end
         end
      end
   end

   // One-hot ready toward the granted input; held low during reset
   always_comb begin
      in_ready = '0;
      if (xfer_in) begin
         in_ready[gsel] = 1'b1;
      end
   end

   // Output register occupancy: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (xfer_in) state_d = FULL;
         FULL: begin
            if (xfer_in)        state_d = FULL;
            else if (out_ready) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   // Output register occupancy: state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // ---- stage p0: captured beat and its source index ----
   // Beat capture; payload holds its value after being drained
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_p0 <= '0;
         src_p0  <= '0;
      end else if (xfer_in) begin
         data_p0 <= in_data[int'(gsel)*WIDTH +: WIDTH];
         src_p0  <= gsel;
      end
   end

   // Round-robin pointer: last rotate-mode winner; reset so the first search starts at 0
   always_ff @(posedge clk) begin
      if (!rst_n)              ptr_p0 <= SEL_W'(N - 1);
      else if (xfer_in && mode) ptr_p0 <= gsel;
   end

   assign out_data  = data_p0;
   assign out_src   = src_p0;
   assign out_valid = (state_q == FULL);

`ifdef ARB_MUX_STATS_EN
   logic [15:0] cnt_p0;

   // Transfer-in counter, wraps naturally at 16 bits
   always_ff @(posedge clk) begin
      if (!rst_n)       cnt_p0 <= '0;
      else if (xfer_in) cnt_p0 <= cnt_p0 + 16'd1;
   end

   assign xfer_count = cnt_p0;
`endif

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux (N=16, WIDTH=32). The driver pushes the
// hand-computed beat on every expected grant; the monitor pops and compares
// on each output handshake. Stats checks run when ARB_MUX_STATS_EN is defined.
module tb_arb_mux;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  s;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [511:0]  in_data;
   logic [15:0]   in_valid;
   logic [15:0]   in_ready;
   logic          mode;
   logic [3:0]    control;
   logic [31:0]   out_data;
   logic [3:0]    out_src;
   logic          out_valid;
   logic          out_ready;
`ifdef ARB_MUX_STATS_EN
   logic [15:0]   xfer_count;
`endif

   logic [31:0]   din [16];
   beat_t         sb [$];
   int            checks = 0;
   int            errors = 0;

   arb_mux #(.WIDTH(32), .N(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .control   (control),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef ARB_MUX_STATS_EN
      ,
      .xfer_count(xfer_count)
`endif
   );

   always #5 clk = ~clk;

   always_comb begin
      in_data = '0;
      for (int i = 0; i < 16; i++) in_data[i*32 +: 32] = din[i];
   end

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // One cycle of stimulus: drive at negedge, check ready, queue expected beat
   task automatic drive(input logic rn, input logic m, input logic [3:0] c,
                        input logic [15:0] v, input logic ordy,
                        input logic [15:0] exp_rdy, input string nm);
      beat_t b;
      @(negedge clk);
      rst_n     = rn;
      mode      = m;
      control   = c;
      in_valid  = v;
      out_ready = ordy;
      #1;
      chk(nm, 64'(in_ready), 64'(exp_rdy));
      if (exp_rdy != 16'h0) begin
         for (int i = 0; i < 16; i++) begin
            if (exp_rdy[i]) begin
               b.d = din[i];
               b.s = 4'(i);
            end
         end
         sb.push_back(b);
      end
   endtask

   // Monitor: compare each beat the consumer takes against the scoreboard
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         #2;
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL mon_unexpected: got beat %0h src %0d expected none", out_data, out_src);
            end else begin
               e = sb.pop_front();
               chk("mon_data", 64'(out_data), 64'(e.d));
               chk("mon_src", 64'(out_src), 64'(e.s));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) din[i] = 32'h1000_0000 | (32'(i) * 32'h111);
      din[5]    = 32'hDEADBEEF;
      rst_n     = 1'b0;
      mode      = 1'b0;
      control   = 4'd0;
      in_valid  = 16'hFFFF;
      out_ready = 1'b1;

      // Reset: two cycles with every input valid
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'h0);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_data", 64'(out_data), 64'h0);
      chk("rst_out_src", 64'(out_src), 64'h0);

      // Fixed mode
      drive(1, 0, 4'd5, 16'hFFFF, 1, 16'h0020, "fix_ctrl5");
      drive(1, 0, 4'd7, 16'hFF7F, 1, 16'h0000, "fix_ctrl7_novalid");
      chk("fix_out_data", 64'(out_data), 64'hDEADBEEF);
      chk("fix_out_src", 64'(out_src), 64'd5);
      drive(1, 0, 4'd0, 16'h0000, 1, 16'h0000, "fix_idle");
      chk("fix_drained", 64'(out_valid), 64'h0);

      // Rotate fairness with wrap-around
      drive(1, 1, 4'd0, 16'h8003, 1, 16'h0001, "rr_g0");
      drive(1, 1, 4'd0, 16'h8003, 1, 16'h0002, "rr_g1");
      drive(1, 1, 4'd0, 16'h8003, 1, 16'h8000, "rr_g15");
      drive(1, 1, 4'd0, 16'h8003, 1, 16'h0001, "rr_wrap_g0");
      drive(1, 1, 4'd0, 16'h8003, 1, 16'h0002, "rr_g1b");
      drive(1, 1, 4'd0, 16'h8003, 1, 16'h8000, "rr_g15b");
      drive(1, 1, 4'd0, 16'h0000, 1, 16'h0000, "rr_idle");

      // Backpressure: hold FULL for 4 cycles, then reload with no bubble
      drive(1, 1, 4'd0, 16'h8003, 1, 16'h0001, "bp_load");
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 4'd0, 16'h8003, 0, 16'h0000, "bp_stall_rdy");
         chk("bp_stall_data", 64'(out_data), 64'(din[0]));
         chk("bp_stall_src", 64'(out_src), 64'd0);
         chk("bp_stall_valid", 64'(out_valid), 64'h1);
      end
      drive(1, 1, 4'd0, 16'h8003, 1, 16'h0002, "bp_release");
      drive(1, 1, 4'd0, 16'h0000, 1, 16'h0000, "bp_idle");
      chk("bp_next_src", 64'(out_src), 64'd1);
      chk("bp_next_valid", 64'(out_valid), 64'h1);
      drive(1, 1, 4'd0, 16'h0000, 1, 16'h0000, "bp_idle2");

      // Mode switch: pointer survives fixed-mode transfers
      drive(1, 1, 4'd0, 16'h0008, 1, 16'h0008, "ms_rr_g3");
      drive(1, 0, 4'd9, 16'hFFFF, 1, 16'h0200, "ms_fix9a");
      drive(1, 0, 4'd9, 16'hFFFF, 1, 16'h0200, "ms_fix9b");
      drive(1, 1, 4'd9, 16'hFFFF, 1, 16'h0010, "ms_rr_g4");
      drive(1, 1, 4'd0, 16'h0000, 1, 16'h0000, "ms_idle");

      // Reset mid-operation discards the held beat and blocks ready
      drive(1, 0, 4'd2, 16'hFFFF, 1, 16'h0004, "mr_load");
      drive(0, 0, 4'd2, 16'hFFFF, 1, 16'h0000, "mr_rst_ready");
      drive(1, 0, 4'd2, 16'h0000, 1, 16'h0000, "mr_idle");
      chk("mr_out_valid", 64'(out_valid), 64'h0);
      chk("mr_out_data", 64'(out_data), 64'h0);
      chk("mr_out_src", 64'(out_src), 64'h0);
      drive(1, 1, 4'd0, 16'hFFFF, 1, 16'h0001, "mr_ptr_reset_g0");
      drive(1, 1, 4'd0, 16'h0000, 1, 16'h0000, "mr_idle2");

`ifdef ARB_MUX_STATS_EN
      // Stats: counter wraps after 65536 transfers and clears on reset
      drive(0, 0, 4'd0, 16'h0000, 1, 16'h0000, "st_rst");
      drive(1, 0, 4'd0, 16'h0000, 1, 16'h0000, "st_idle0");
      chk("st_cnt_zero", 64'(xfer_count), 64'h0);
      for (int i = 0; i < 65537; i++) begin
         drive(1, 0, 4'd0, 16'h0001, 1, 16'h0001, "st_xfer");
      end
      drive(1, 0, 4'd0, 16'h0000, 1, 16'h0000, "st_idle1");
      chk("st_cnt_wrap", 64'(xfer_count), 64'h1);
      drive(1, 0, 4'd0, 16'h0001, 1, 16'h0001, "st_xfer2");
      drive(0, 0, 4'd0, 16'h0001, 1, 16'h0000, "st_mid_rst");
      drive(1, 0, 4'd0, 16'h0000, 1, 16'h0000, "st_idle2");
      chk("st_cnt_cleared", 64'(xfer_count), 64'h0);
`endif

      repeat (2) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
